// File: rtl/sram_stage_sequencer.sv
// Owns the single SRAM port: UART image download, then processing stages run in index order, then VGA.
// Stage handshake: Stage_start[k] pulses one cycle on entry; Stage_finish[k] is taken on any cycle of stage k, including the start cycle.
module sram_stage_sequencer #(
    parameter int NUM_STAGES    = 3,
    parameter int ADDR_W        = 18,
    parameter int DATA_W        = 16,
    parameter int TIMER_W       = 26,
    parameter int UART_TIMEOUT  = 50000000,
    parameter int STAGE_TIMEOUT = 0
) (
    input  logic                         Clock,
    input  logic                         Resetn,
    input  logic                         UART_RX_I,
    output logic                         UART_rx_initialize,
    output logic                         UART_rx_enable,
    input  logic [ADDR_W-1:0]            UART_SRAM_address,
    input  logic [DATA_W-1:0]            UART_SRAM_write_data,
    input  logic                         UART_SRAM_we_n,
    input  logic [NUM_STAGES-1:0]        Stage_enable_mask,
    output logic [NUM_STAGES-1:0]        Stage_start,
    input  logic [NUM_STAGES-1:0]        Stage_finish,
    input  logic [NUM_STAGES*ADDR_W-1:0] Stage_SRAM_address,
    input  logic [NUM_STAGES*DATA_W-1:0] Stage_SRAM_write_data,
    input  logic [NUM_STAGES-1:0]        Stage_SRAM_we_n,
    input  logic [ADDR_W-1:0]            VGA_SRAM_address,
    output logic                         VGA_enable,
    output logic [ADDR_W-1:0]            SRAM_address,
    output logic [DATA_W-1:0]            SRAM_write_data,
    output logic                         SRAM_we_n,
    output logic                         Busy,
    output logic [2:0]                   Current_stage,
    output logic                         Stage_error,
    output logic [2:0]                   Error_stage,
    output logic [1:0]                   o_dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_UART_RX = 2'd1,
        S_STAGE   = 2'd2
    } state_t;

    localparam logic [TIMER_W-1:0] UART_LAST  = TIMER_W'(UART_TIMEOUT - 1);
    localparam logic [TIMER_W-1:0] STAGE_LAST = TIMER_W'((STAGE_TIMEOUT == 0) ? 0 : STAGE_TIMEOUT - 1);
    localparam bit                 WDOG_EN    = (STAGE_TIMEOUT != 0);

    state_t                r_state;
    logic [NUM_STAGES-1:0] r_mask;
    logic [NUM_STAGES-1:0] r_start;
    logic [2:0]            r_cur;
    logic [2:0]            r_err_stage;
    logic                  r_err;
    logic                  r_vga_en;
    logic                  r_init;
    logic                  r_enable;
    logic [TIMER_W-1:0]    r_uart_timer;
    logic [TIMER_W-1:0]    r_stage_timer;

    logic [3:0]            w_first;
    logic [3:0]            w_next;
    logic                  w_finish;
    logic                  w_watchdog;

    function automatic logic [NUM_STAGES-1:0] f_onehot(input logic [2:0] idx);
        logic [NUM_STAGES-1:0] v;
        v = '0;
        for (int k = 0; k < NUM_STAGES; k++) v[k] = (idx == 3'(k));
        return v;
    endfunction

    // Returns {found, index} of the lowest set mask bit at or above lo.
    function automatic logic [3:0] f_pick(input logic [NUM_STAGES-1:0] mask, input logic [3:0] lo);
        logic [3:0] v;
        v = '0;
        for (int k = NUM_STAGES - 1; k >= 0; k--) begin
            if (mask[k] && (4'(k) >= lo)) v = {1'b1, 3'(k)};
        end
        return v;
    endfunction

    assign w_first    = f_pick(Stage_enable_mask, 4'd0);
    assign w_next     = f_pick(r_mask, {1'b0, r_cur} + 4'd1);
    assign w_finish   = |(Stage_finish & f_onehot(r_cur));
    assign w_watchdog = WDOG_EN && (r_stage_timer == STAGE_LAST);

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            r_state       <= S_IDLE;
            r_mask        <= '0;
            r_start       <= '0;
            r_cur         <= '0;
            r_err_stage   <= '0;
            r_err         <= 1'b0;
            r_vga_en      <= 1'b1;
            r_init        <= 1'b0;
            r_enable      <= 1'b0;
            r_uart_timer  <= '0;
            r_stage_timer <= '0;
        end else begin
            r_uart_timer <= r_uart_timer + 1'b1;
            r_init       <= 1'b0;
            r_enable     <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_vga_en      <= 1'b1;
                    r_stage_timer <= '0;
                    if (!UART_RX_I) begin
                        r_init       <= 1'b1;
                        r_uart_timer <= '0;
                        r_vga_en     <= 1'b0;
                        r_err        <= 1'b0;
                        r_state      <= S_UART_RX;
                    end
                end
                S_UART_RX: begin
                    r_enable <= r_init;
                    if (!UART_SRAM_we_n) r_uart_timer <= '0;
                    // Download ends after UART_TIMEOUT idle cycles; the stage mask is frozen here.
                    if (r_uart_timer == UART_LAST) begin
                        r_uart_timer <= '0;
                        r_mask       <= Stage_enable_mask;
                        if (w_first[3]) begin
                            r_state       <= S_STAGE;
                            r_cur         <= w_first[2:0];
                            r_start       <= f_onehot(w_first[2:0]);
                            r_stage_timer <= '0;
                        end else begin
                            r_state  <= S_IDLE;
                            r_vga_en <= 1'b1;
                        end
                    end
                end
                S_STAGE: begin
                    r_start       <= '0;
                    r_stage_timer <= r_stage_timer + 1'b1;
                    if (w_finish) begin
                        if (w_next[3]) begin
                            r_cur         <= w_next[2:0];
                            r_start       <= f_onehot(w_next[2:0]);
                            r_stage_timer <= '0;
                        end else begin
                            r_state  <= S_IDLE;
                            r_vga_en <= 1'b1;
                        end
                    end else if (w_watchdog) begin
                        r_err       <= 1'b1;
                        r_err_stage <= r_cur;
                        r_state     <= S_IDLE;
                        r_vga_en    <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        SRAM_address    = VGA_SRAM_address;
        SRAM_write_data = '0;
        SRAM_we_n       = 1'b1;
        case (r_state)
            S_UART_RX: begin
                SRAM_address    = UART_SRAM_address;
                SRAM_write_data = UART_SRAM_write_data;
                SRAM_we_n       = UART_SRAM_we_n;
            end
            S_STAGE: begin
                for (int k = 0; k < NUM_STAGES; k++) begin
                    if (r_cur == 3'(k)) begin
                        SRAM_address    = Stage_SRAM_address[k*ADDR_W +: ADDR_W];
                        SRAM_write_data = Stage_SRAM_write_data[k*DATA_W +: DATA_W];
                        SRAM_we_n       = Stage_SRAM_we_n[k];
                    end
                end
            end
            default: ;
        endcase
    end

    assign UART_rx_initialize = r_init;
    assign UART_rx_enable     = r_enable;
    assign Stage_start        = r_start;
    assign VGA_enable         = r_vga_en;
    assign Busy               = (r_state != S_IDLE);
    assign Current_stage      = r_cur;
    assign Stage_error        = r_err;
    assign Error_stage        = r_err_stage;
    assign o_dbg_state        = r_state;

endmodule

// File: tb/tb_sram_stage_sequencer.sv
// Bench for sram_stage_sequencer: table of whole runs plus random runs, each checked cycle by cycle
// against a stage timeline computed from mask and per-stage finish delays.
module tb_sram_stage_sequencer;

    localparam int NS  = 3;
    localparam int AW  = 18;
    localparam int DW  = 16;
    localparam int TW  = 26;
    localparam int UTO = 100;
    localparam int STO = 50;
    localparam int NEVER = 1000;

    logic             Clock = 1'b0;
    logic             Resetn;
    logic             UART_RX_I;
    logic             UART_rx_initialize;
    logic             UART_rx_enable;
    logic [AW-1:0]    UART_SRAM_address;
    logic [DW-1:0]    UART_SRAM_write_data;
    logic             UART_SRAM_we_n;
    logic [NS-1:0]    Stage_enable_mask;
    logic [NS-1:0]    Stage_start;
    logic [NS-1:0]    Stage_finish;
    logic [NS*AW-1:0] Stage_SRAM_address;
    logic [NS*DW-1:0] Stage_SRAM_write_data;
    logic [NS-1:0]    Stage_SRAM_we_n;
    logic [AW-1:0]    VGA_SRAM_address;
    logic             VGA_enable;
    logic [AW-1:0]    SRAM_address;
    logic [DW-1:0]    SRAM_write_data;
    logic             SRAM_we_n;
    logic             Busy;
    logic [2:0]       Current_stage;
    logic             Stage_error;
    logic [2:0]       Error_stage;
    logic [1:0]       w_dbg_state;

    sram_stage_sequencer #(
        .NUM_STAGES(NS), .ADDR_W(AW), .DATA_W(DW), .TIMER_W(TW),
        .UART_TIMEOUT(UTO), .STAGE_TIMEOUT(STO)
    ) dut (
        .Clock(Clock), .Resetn(Resetn), .UART_RX_I(UART_RX_I),
        .UART_rx_initialize(UART_rx_initialize), .UART_rx_enable(UART_rx_enable),
        .UART_SRAM_address(UART_SRAM_address), .UART_SRAM_write_data(UART_SRAM_write_data),
        .UART_SRAM_we_n(UART_SRAM_we_n), .Stage_enable_mask(Stage_enable_mask),
        .Stage_start(Stage_start), .Stage_finish(Stage_finish),
        .Stage_SRAM_address(Stage_SRAM_address), .Stage_SRAM_write_data(Stage_SRAM_write_data),
        .Stage_SRAM_we_n(Stage_SRAM_we_n), .VGA_SRAM_address(VGA_SRAM_address),
        .VGA_enable(VGA_enable), .SRAM_address(SRAM_address), .SRAM_write_data(SRAM_write_data),
        .SRAM_we_n(SRAM_we_n), .Busy(Busy), .Current_stage(Current_stage),
        .Stage_error(Stage_error), .Error_stage(Error_stage), .o_dbg_state(w_dbg_state)
    );

    // Clock / reset
    always #5 Clock = ~Clock;

    initial begin
        #5000000;
        $display("FAIL global_timeout: simulation still running at t=%0t, required end earlier", $time);
        $fatal(1, "global timeout");
    end

    // Scoreboard counters
    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference timeline: start vector and active stage for each cycle after the download ends.
    logic [NS-1:0] m_start[256];
    int            m_act[256];
    int            m_end;
    bit            m_err;
    int            m_estage;

    task automatic build_model(input logic [NS-1:0] mask, input int d[NS]);
        int t;
        int span;
        t = 0;
        m_err = 1'b0;
        m_estage = 0;
        for (int i = 0; i < 256; i++) begin
            m_start[i] = '0;
            m_act[i] = 0;
        end
        for (int k = 0; k < NS; k++) begin
            if (mask[k] && !m_err) begin
                m_start[t][k] = 1'b1;
                span = (d[k] < STO) ? d[k] + 1 : STO;
                for (int i = t; i < t + span; i++) m_act[i] = k;
                if (d[k] >= STO) begin
                    m_err = 1'b1;
                    m_estage = k;
                end
                t += span;
            end
        end
        m_end = t;
    endtask

    // Driver tasks
    task automatic rnd_side(input bit noise);
        VGA_SRAM_address      = AW'($urandom);
        Stage_SRAM_address    = {AW'($urandom), AW'($urandom), AW'($urandom)};
        Stage_SRAM_write_data = {DW'($urandom), DW'($urandom), DW'($urandom)};
        Stage_SRAM_we_n       = NS'($urandom);
        UART_RX_I             = noise ? 1'($urandom_range(0, 1)) : 1'b1;
    endtask

    task automatic step(input bit noise);
        @(posedge Clock);
        #1;
        rnd_side(noise);
        #1;
    endtask

    task automatic chk_reset_state(input string name);
        chk(name,
            {Busy, VGA_enable, UART_rx_initialize, UART_rx_enable, Stage_start, Stage_error,
             Current_stage, Error_stage, SRAM_we_n, SRAM_address},
            {1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 3'd0, 3'd0, 1'b1, VGA_SRAM_address});
    endtask

    task automatic run_flow(input logic [NS-1:0] mask, input int d[NS], input int nwr,
                            input bit spur, output int idle_c);
        int            n;
        int            fin_at[NS];
        logic [DW-1:0] wd;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        logic          ew;
        logic [2:0]    ecur;
        logic          eb;
        logic [43:0]   v_act;
        logic [43:0]   v_exp;

        build_model(mask, d);
        Stage_enable_mask = mask;
        UART_RX_I = 1'b0;
        step(0);
        chk("uart_start", {UART_rx_initialize, UART_rx_enable, Busy, VGA_enable, Stage_error, Stage_start},
            {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'b000});

        for (int i = 0; i < nwr; i++) begin
            wd = DW'($urandom);
            UART_SRAM_address = AW'(i);
            UART_SRAM_write_data = wd;
            UART_SRAM_we_n = 1'b0;
            #1;
            chk("uart_mux", {SRAM_address, SRAM_write_data, SRAM_we_n}, {AW'(i), wd, 1'b0});
            step(1);
            if (i == 0) chk("rx_enable_pulse", {UART_rx_initialize, UART_rx_enable}, 2'b01);
            if (i == 1) chk("rx_enable_end", {UART_rx_initialize, UART_rx_enable}, 2'b00);
        end
        UART_SRAM_we_n = 1'b1;

        n = 0;
        do begin
            step(0);
            n++;
        end while (Stage_start == '0 && Busy && n < 300);
        chk("uart_timeout_cycles", n, UTO);

        for (int k = 0; k < NS; k++) fin_at[k] = -1;
        idle_c = -1;
        Stage_enable_mask = NS'($urandom);
        for (int c = 0; c <= m_end; c++) begin
            if (c > 0) step(c < m_end);
            eb = (c < m_end);
            if (eb) begin
                ea   = Stage_SRAM_address[m_act[c]*AW +: AW];
                ed   = Stage_SRAM_write_data[m_act[c]*DW +: DW];
                ew   = Stage_SRAM_we_n[m_act[c]];
                ecur = 3'(m_act[c]);
            end else begin
                ea   = VGA_SRAM_address;
                ed   = '0;
                ew   = 1'b1;
                ecur = 3'd0;
            end
            v_exp = {m_start[c], eb, ecur, (m_err && !eb), !eb, ea, ed, ew};
            v_act = {Stage_start, Busy, (Busy ? Current_stage : 3'd0), Stage_error, VGA_enable,
                     SRAM_address, SRAM_write_data, SRAM_we_n};
            chk("stage_cycle", v_act, v_exp);
            if (!Busy && idle_c < 0) idle_c = c;
            for (int k = 0; k < NS; k++) begin
                if (Stage_start[k] && d[k] < NEVER) fin_at[k] = c + d[k];
                Stage_finish[k] = (fin_at[k] == c) || (spur && !mask[k]);
            end
        end
        Stage_finish = '0;
        if (m_err) chk("error_stage", Error_stage, 3'(m_estage));

        n = 0;
        while (Busy && n < 300) begin
            step(0);
            n++;
        end
        chk("end_idle", {Busy, VGA_enable}, 2'b01);
    endtask

    typedef struct {
        logic [NS-1:0] mask;
        int            d0;
        int            d1;
        int            d2;
        bit            spur;
        bit            exp_err;
        int            exp_estage;
        int            exp_end;
    } vec_t;

    vec_t tbl[7];

    initial begin
        int dd[NS];
        int idle_c;
        int n;
        logic [NS-1:0] rmask;
        int sel;

        Resetn = 1'b0;
        UART_SRAM_address = '0;
        UART_SRAM_write_data = '0;
        UART_SRAM_we_n = 1'b1;
        Stage_enable_mask = '0;
        Stage_finish = '0;
        rnd_side(0);

        tbl[0] = '{3'b111, 10, 10, 10, 1'b0, 1'b0, 0, 33};
        tbl[1] = '{3'b101, 10, 0, 10, 1'b1, 1'b0, 0, 22};
        tbl[2] = '{3'b111, 5, NEVER, 3, 1'b0, 1'b1, 1, 56};
        tbl[3] = '{3'b000, 0, 0, 0, 1'b0, 1'b0, 0, 0};
        tbl[4] = '{3'b011, 49, 3, 0, 1'b0, 1'b0, 0, 54};
        tbl[5] = '{3'b100, 0, 0, 0, 1'b1, 1'b0, 0, 1};
        tbl[6] = '{3'b001, 50, 0, 0, 1'b0, 1'b1, 0, 50};

        repeat (3) step(0);
        chk_reset_state("reset_init");
        Resetn = 1'b1;
        step(0);
        step(0);
        chk("idle_hold", {Busy, VGA_enable, Stage_start}, {1'b0, 1'b1, 3'b000});

        for (int i = 0; i < 7; i++) begin
            dd[0] = tbl[i].d0;
            dd[1] = tbl[i].d1;
            dd[2] = tbl[i].d2;
            run_flow(tbl[i].mask, dd, 1 + (i % 4), tbl[i].spur, idle_c);
            chk("tbl_end_cycle", idle_c, tbl[i].exp_end);
            chk("tbl_error", Stage_error, tbl[i].exp_err);
            if (tbl[i].exp_err) chk("tbl_error_stage", Error_stage, 3'(tbl[i].exp_estage));
        end

        for (int r = 0; r < 20; r++) begin
            rmask = NS'($urandom);
            for (int k = 0; k < NS; k++) begin
                sel = $urandom_range(0, 9);
                if (sel < 7)       dd[k] = $urandom_range(0, 12);
                else if (sel == 7) dd[k] = $urandom_range(STO - 2, STO + 1);
                else if (sel == 8) dd[k] = NEVER;
                else               dd[k] = 0;
            end
            run_flow(rmask, dd, $urandom_range(1, 4), 1'($urandom_range(0, 1)), idle_c);
        end

        // Reset while stage 1 is running.
        Stage_enable_mask = 3'b111;
        UART_RX_I = 1'b0;
        step(0);
        UART_SRAM_we_n = 1'b0;
        step(0);
        UART_SRAM_we_n = 1'b1;
        n = 0;
        while (!Stage_start[0] && n < 300) begin
            step(0);
            n++;
        end
        chk("reset_pre_wait", n, UTO);
        Stage_finish = 3'b001;
        step(0);
        Stage_finish = '0;
        chk("reset_pre_stage1", {Stage_start, Current_stage, Busy}, {3'b010, 3'd1, 1'b1});
        step(0);
        step(0);
        Resetn = 1'b0;
        step(0);
        chk_reset_state("reset_mid_stage");
        Resetn = 1'b1;
        step(0);
        chk("reset_release", {Busy, VGA_enable, Stage_start}, {1'b0, 1'b1, 3'b000});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sram_stage_sequencer.md
Name: sram_stage_sequencer

Overview:
Parametrised top-level SRAM owner and sequencer for the decoder datapath. After a UART image download times out, it runs up to NUM_STAGES processing stages (M1, M2, M3, ...) in index order, each through a start/finish handshake. It muxes the single SRAM port between the UART, the active stage and VGA. Over the fixed single-stage flow it adds a per-run stage-skip mask, a per-stage watchdog and status outputs.

Parameters:
NUM_STAGES, 3, number of processing stages (1..8)
ADDR_W, 18, SRAM address width
DATA_W, 16, SRAM data width
TIMER_W, 26, width of the UART and watchdog timers
UART_TIMEOUT, 50000000, idle cycles on UART writes that end the download
STAGE_TIMEOUT, 0, cycles allowed per stage before abort; 0 disables the watchdog

Ports:
Clock  in  1  system clock (50 MHz)
Resetn  in  1  synchronous active-low reset
UART_RX_I  in  1  raw UART line; low means start bit
UART_rx_initialize  out  1  UART interface init pulse
UART_rx_enable  out  1  UART interface enable pulse
UART_SRAM_address  in  ADDR_W  UART write address
UART_SRAM_write_data  in  DATA_W  UART write data
UART_SRAM_we_n  in  1  UART write strobe, active low
Stage_enable_mask  in  NUM_STAGES  bit k=1 runs stage k; latched at download end
Stage_start  out  NUM_STAGES  one-cycle start pulse per stage
Stage_finish  in  NUM_STAGES  finish pulse per stage
Stage_SRAM_address  in  NUM_STAGES*ADDR_W  stage k address in slice [k*ADDR_W +: ADDR_W]
Stage_SRAM_write_data  in  NUM_STAGES*DATA_W  stage k write data, sliced the same way
Stage_SRAM_we_n  in  NUM_STAGES  stage k write strobe, active low
VGA_SRAM_address  in  ADDR_W  VGA read address
VGA_enable  out  1  VGA unit enable
SRAM_address  out  ADDR_W  to SRAM controller
SRAM_write_data  out  DATA_W  to SRAM controller
SRAM_we_n  out  1  to SRAM controller
Busy  out  1  high in any state other than S_IDLE
Current_stage  out  3  index of the active or last-run stage
Stage_error  out  1  sticky watchdog abort flag
Error_stage  out  3  index of the stage that timed out

Behaviour:
- Reset (Resetn=0 at a Clock edge) has priority over everything and aborts any operation mid-run.
  - State goes to S_IDLE, VGA_enable=1.
  - UART_rx_initialize, UART_rx_enable, Stage_start, Stage_error, Busy = 0.
  - Current_stage = 0, Error_stage = 0, both timers = 0, latched mask = 0.
- Timers:
  - uart_timer increments every cycle by default and wraps at TIMER_W.
  - stage_timer clears on entry to a stage and increments while in S_STAGE.
- S_IDLE: VGA_enable=1. On UART_RX_I=0:
  - UART_rx_initialize<=1, uart_timer<=0, VGA_enable<=0, Stage_error<=0.
  - Go to S_UART_RX.
- S_UART_RX:
  - UART_rx_initialize<=0. UART_rx_enable<=UART_rx_initialize, so enable is a one-cycle pulse the cycle after init.
  - uart_timer<=0 on any cycle with UART_SRAM_we_n=0.
  - When uart_timer==UART_TIMEOUT-1: latch Stage_enable_mask, uart_timer<=0.
  - Then go to S_STAGE with k = lowest set mask bit. If the mask is all zero, go to S_IDLE.
- S_STAGE (stage k):
  - Stage_start[k] is high for exactly the first cycle in state, once per entry. Current_stage=k.
  - Stage_finish[k] is accepted on any cycle in state, including the start cycle.
  - On finish, go to the next higher set mask bit. If there is none, go to S_IDLE.
  - Stage_finish[j] for j != k is ignored.
  - Watchdog (only when STAGE_TIMEOUT != 0): if stage_timer==STAGE_TIMEOUT-1 without finish, set Stage_error<=1 and Error_stage<=k, then go to S_IDLE.
  - Finish in the same cycle as the timeout: finish wins and no error is raised.
- Consecutive stages: going from stage k to stage m gives Stage_start[m] in the cycle right after finish[k]. There are no idle cycles between stages.
- SRAM mux (combinational, based on current state):
  - S_UART_RX: SRAM port driven by the UART inputs.
  - S_STAGE k: SRAM port driven by stage k's slices.
  - Otherwise: address=VGA_SRAM_address, write data=0, we_n=1.
- UART_RX_I activity outside S_IDLE is ignored.
- Mask changes after the latch point have no effect until the next run.

Test Plan:
- Reset mid-S_STAGE (stage 1 active) -> next edge: S_IDLE, VGA_enable=1, Stage_start=0, Busy=0, SRAM_we_n=1, SRAM_address=VGA_SRAM_address.
- UART_RX_I low, 4 UART writes (addr 0..3, data 16'hA5A5), then silence, with UART_TIMEOUT=100 -> init pulse 1 cycle, enable pulse the next cycle; SRAM mirrors the UART port; Stage_start[0] rises exactly 100 cycles after the last write.
- Mask=3'b111, each stage finishing 10 cycles after its start -> start pulses in order 0, 1, 2; each next start lands the cycle after the previous finish; S_IDLE after finish[2]; SRAM port follows the active stage slice.
- Mask=3'b101 -> stage 1 never started; Stage_start[2] the cycle after finish[0]; spurious finish[1] during stage 0 is ignored.
- STAGE_TIMEOUT=50, stage 1 never finishes -> cycle 50 in stage: Stage_error=1, Error_stage=1, S_IDLE; a new UART start clears Stage_error.
- Mask=3'b000 -> S_IDLE right after the timeout with no starts; finish[0] in the same cycle as the watchdog expiry -> no error, advance to the next stage.
